sync_fifo_flags: RTL and testbench



---
 rtl/sync_fifo_flags_pkg.sv | 15 +
 rtl/sync_fifo_flags_mem.sv | 25 ++
 rtl/sync_fifo_flags.sv | 107 ++++++++++
 tb/tb_sync_fifo_flags.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_flags_pkg.sv
// Shared types and defaults for the single-clock flagged FIFO.
package sync_fifo_flags_pkg;

  localparam int DEF_DW       = 32;
  localparam int DEF_ADDRSIZE = 4;

  // Status flags derived from the pointer registers.
  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
  } fifo_flags_t;

endpackage

// File: rtl/sync_fifo_flags_mem.sv
// Storage array: synchronous write, asynchronous read (distributed-RAM friendly).
module fifo_mem_1clk #(
  parameter int DW       = 32,
  parameter int ADDRSIZE = 4
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDRSIZE-1:0] waddr,
  input  logic [DW-1:0]       wdata,
  input  logic [ADDRSIZE-1:0] raddr,
  output logic [DW-1:0]       rdata
);

  localparam int DEPTH = 1 << ADDRSIZE;

  logic [DW-1:0] r_mem [DEPTH];

  // Write port; contents are intentionally never reset.
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with level, almost flags, FWFT/registered read and error pulses.
module sync_fifo_flags
  import sync_fifo_flags_pkg::*;
#(
  parameter int DW        = DEF_DW,
  parameter int ADDRSIZE  = DEF_ADDRSIZE,
  parameter int AFULL_TH  = (1 << ADDRSIZE) - 2,
  parameter int AEMPTY_TH = 2,
  parameter bit FWFT      = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [DW-1:0]       wr_data,
  output logic                full,
  output logic                almost_full,
  input  logic                rd_en,
  output logic [DW-1:0]       rd_data,
  output logic                empty,
  output logic                almost_empty,
  output logic [ADDRSIZE:0]   level,
  output logic                overflow,
  output logic                underflow
);

  localparam int DEPTH = 1 << ADDRSIZE;
  localparam int LVL_W = ADDRSIZE + 1;

  logic [ADDRSIZE:0] r_wr_ptr;
  logic [ADDRSIZE:0] r_rd_ptr;
  logic              r_overflow;
  logic              r_underflow;
  logic [ADDRSIZE:0] w_level;
  fifo_flags_t       w_flags;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [DW-1:0]     w_mem_rdata;

  // Level and flags depend only on the pointer registers, so no input paths reach them.
  assign w_level                = r_wr_ptr - r_rd_ptr;
  assign w_flags.empty          = (w_level == '0);
  assign w_flags.full           = (w_level == LVL_W'(DEPTH));
  assign w_flags.almost_full    = (w_level >= LVL_W'(AFULL_TH));
  assign w_flags.almost_empty   = (w_level <= LVL_W'(AEMPTY_TH));

  // A write at full is rejected even if a read frees a slot on the same edge.
  assign w_wr_acc = wr_en && !w_flags.full;
  assign w_rd_acc = rd_en && !w_flags.empty;

  // Pointer advance on accepted requests only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // One-cycle error pulses for rejected requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= wr_en && w_flags.full;
      r_underflow <= rd_en && w_flags.empty;
    end
  end

  fifo_mem_1clk #(
    .DW       (DW),
    .ADDRSIZE (ADDRSIZE)
  ) u_mem (
    .clk   (clk),
    .we    (w_wr_acc),
    .waddr (r_wr_ptr[ADDRSIZE-1:0]),
    .wdata (wr_data),
    .raddr (r_rd_ptr[ADDRSIZE-1:0]),
    .rdata (w_mem_rdata)
  );

  generate
    if (FWFT) begin : g_fwft
      // Head word is visible as soon as it is stored.
      assign rd_data = w_mem_rdata;
    end else begin : g_regrd
      logic [DW-1:0] r_rd_data;
      // Capture the head word on an accepted read, hold otherwise.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_rd_data <= '0;
        else if (w_rd_acc) r_rd_data <= w_mem_rdata;
      end
      assign rd_data = r_rd_data;
    end
  endgenerate

  assign full         = w_flags.full;
  assign almost_full  = w_flags.almost_full;
  assign empty        = w_flags.empty;
  assign almost_empty = w_flags.almost_empty;
  assign level        = w_level;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench: FWFT instance (a_*) and registered-read instance (b_*).
module tb_sync_fifo_flags;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic          a_wr_en = 0, a_rd_en = 0;
  logic [DW-1:0] a_wr_data = '0;
  logic          a_full, a_afull, a_empty, a_aempty, a_ovf, a_unf;
  logic [DW-1:0] a_rd_data;
  logic [AW:0]   a_level;

  logic          b_wr_en = 0, b_rd_en = 0;
  logic [DW-1:0] b_wr_data = '0;
  logic          b_full, b_afull, b_empty, b_aempty, b_ovf, b_unf;
  logic [DW-1:0] b_rd_data;
  logic [AW:0]   b_level;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] q[$];

  always #5 clk = ~clk;

  sync_fifo_flags #(.DW(DW), .ADDRSIZE(AW), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .wr_en(a_wr_en), .wr_data(a_wr_data), .full(a_full),
    .almost_full(a_afull), .rd_en(a_rd_en), .rd_data(a_rd_data), .empty(a_empty),
    .almost_empty(a_aempty), .level(a_level), .overflow(a_ovf), .underflow(a_unf));

  sync_fifo_flags #(.DW(DW), .ADDRSIZE(AW), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .wr_en(b_wr_en), .wr_data(b_wr_data), .full(b_full),
    .almost_full(b_afull), .rd_en(b_rd_en), .rd_data(b_rd_data), .empty(b_empty),
    .almost_empty(b_aempty), .level(b_level), .overflow(b_ovf), .underflow(b_unf));

  // Advance one edge; sample and drive 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (a_level !== 5'd0) begin bad++; $display("FAIL rst_level got=%0d exp=0", a_level); end
    total++; if ({a_empty, a_aempty, a_full, a_afull} !== 4'b1100) begin bad++; $display("FAIL rst_flags got=%b exp=1100", {a_empty, a_aempty, a_full, a_afull}); end
    total++; if ({a_ovf, a_unf, b_ovf, b_unf} !== 4'b0000) begin bad++; $display("FAIL rst_err got=%b exp=0000", {a_ovf, a_unf, b_ovf, b_unf}); end
    total++; if (b_rd_data !== '0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", b_rd_data); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      a_wr_en = 1'b1; a_wr_data = DW'(i);
      q.push_back(DW'(i));
      step();
      total++; if (a_level !== 5'(i + 1)) begin bad++; $display("FAIL fill_level i=%0d got=%0d exp=%0d", i, a_level, i + 1); end
      total++; if (a_afull !== ((i + 1) >= 14)) begin bad++; $display("FAIL fill_afull i=%0d got=%b exp=%b", i, a_afull, (i + 1) >= 14); end
      total++; if (a_full !== ((i + 1) == DEPTH)) begin bad++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, a_full, (i + 1) == DEPTH); end
      total++; if (a_empty !== 1'b0) begin bad++; $display("FAIL fill_empty i=%0d got=%b exp=0", i, a_empty); end
    end
    a_wr_data = 32'hBAD0BAD0;
    step();
    a_wr_en = 1'b0;
    total++; if (a_ovf !== 1'b1) begin bad++; $display("FAIL ovf_pulse got=%b exp=1", a_ovf); end
    total++; if (a_level !== 5'd16) begin bad++; $display("FAIL ovf_level got=%0d exp=16", a_level); end
    step();
    total++; if (a_ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", a_ovf); end
  endtask

  task automatic test_drain();
    while (q.size() > 0) begin
      total++; if (a_rd_data !== q[0]) begin bad++; $display("FAIL drain_data got=%h exp=%h", a_rd_data, q[0]); end
      total++; if (a_aempty !== (q.size() <= 2)) begin bad++; $display("FAIL drain_aempty lvl=%0d got=%b", q.size(), a_aempty); end
      a_rd_en = 1'b1;
      step();
      void'(q.pop_front());
      total++; if (a_level !== 5'(q.size())) begin bad++; $display("FAIL drain_level got=%0d exp=%0d", a_level, q.size()); end
      total++; if (a_empty !== (q.size() == 0)) begin bad++; $display("FAIL drain_empty got=%b exp=%b", a_empty, q.size() == 0); end
    end
    step();
    a_rd_en = 1'b0;
    total++; if (a_unf !== 1'b1) begin bad++; $display("FAIL unf_pulse got=%b exp=1", a_unf); end
    total++; if (a_level !== 5'd0) begin bad++; $display("FAIL unf_level got=%0d exp=0", a_level); end
    step();
    total++; if (a_unf !== 1'b0) begin bad++; $display("FAIL unf_clear got=%b exp=0", a_unf); end
  endtask

  task automatic fill_to(input int n);
    a_rd_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      a_wr_en = 1'b1; a_wr_data = $urandom;
      q.push_back(a_wr_data);
      step();
    end
    a_wr_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    fill_to(8);
    for (int c = 0; c < 100; c++) begin
      total++; if (a_rd_data !== q[0]) begin bad++; $display("FAIL b2b_data c=%0d got=%h exp=%h", c, a_rd_data, q[0]); end
      a_wr_en = 1'b1; a_rd_en = 1'b1; a_wr_data = $urandom;
      q.push_back(a_wr_data);
      step();
      void'(q.pop_front());
      total++; if (a_level !== 5'd8) begin bad++; $display("FAIL b2b_level c=%0d got=%0d exp=8", c, a_level); end
    end
    a_wr_en = 1'b0; a_rd_en = 1'b0;
    test_drain();
  endtask

  task automatic test_full_rw();
    fill_to(16);
    total++; if (a_full !== 1'b1) begin bad++; $display("FAIL frw_full got=%b exp=1", a_full); end
    a_wr_en = 1'b1; a_rd_en = 1'b1; a_wr_data = 32'h5555AAAA;
    step();
    void'(q.pop_front());
    a_wr_en = 1'b0; a_rd_en = 1'b0;
    total++; if (a_level !== 5'd15) begin bad++; $display("FAIL frw_level got=%0d exp=15", a_level); end
    total++; if (a_ovf !== 1'b1) begin bad++; $display("FAIL frw_ovf got=%b exp=1", a_ovf); end
    test_drain();
  endtask

  task automatic test_registered();
    b_wr_en = 1'b1; b_wr_data = 32'hA5A5A5A5;
    step();
    b_wr_en = 1'b0;
    total++; if (b_rd_data !== '0) begin bad++; $display("FAIL reg_pre got=%h exp=0", b_rd_data); end
    b_rd_en = 1'b1;
    step();
    b_rd_en = 1'b0;
    total++; if (b_rd_data !== 32'hA5A5A5A5) begin bad++; $display("FAIL reg_lat got=%h exp=a5a5a5a5", b_rd_data); end
    b_wr_en = 1'b1; b_wr_data = 32'h12345678;
    step();
    b_wr_en = 1'b0;
    step(); step();
    total++; if (b_rd_data !== 32'hA5A5A5A5) begin bad++; $display("FAIL reg_hold got=%h exp=a5a5a5a5", b_rd_data); end
    b_rd_en = 1'b1;
    step();
    b_rd_en = 1'b0;
    total++; if (b_rd_data !== 32'h12345678) begin bad++; $display("FAIL reg_second got=%h exp=12345678", b_rd_data); end
  endtask

  task automatic test_async_reset();
    fill_to(5);
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    total++; if (a_empty !== 1'b1 || a_level !== 5'd0) begin bad++; $display("FAIL arst_now empty=%b level=%0d exp 1/0", a_empty, a_level); end
    #3;
    rst_n = 1'b1;
    step();
    a_wr_en = 1'b1; a_wr_data = 32'hDEADBEEF;
    step();
    a_wr_en = 1'b0;
    total++; if (a_level !== 5'd1) begin bad++; $display("FAIL arst_level got=%0d exp=1", a_level); end
    total++; if (a_rd_data !== 32'hDEADBEEF) begin bad++; $display("FAIL arst_data got=%h exp=deadbeef", a_rd_data); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_full_rw();
    test_registered();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
